load_store_unit: RTL and testbench

Memory-access stage of the RISC-V core. It takes a load or store from execute: the ALU-computed address, the rs2 store data and funct3. It runs a req/ack transaction on the data-memory bus, aligning store data into byte lanes and sign- or zero-extending load data. The extended word is the `data_mem_result` operand of the writeback select stage. The unit stalls the pipeline while a transaction is outstanding, and flags misaligned accesses and bus timeouts.

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack data-bus transaction per load/store,
// aligns store data into byte lanes and extends load data for writeback.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_reg;
    logic        done_reg;
    logic [15:0] cnt_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;

    logic        illegal;
    logic        unaligned;
    logic        accept;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] ext_data;
    logic [15:0] cnt_inc;
    logic        timeout_hit;

    always_comb begin
        illegal = (req_funct3[1:0] == 2'b11)
               || (!req_we && req_funct3 == 3'b110)
               || (req_we && req_funct3[2]);
        unaligned = 1'b0;
        be_next = 4'b1111;
        wdata_next = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_next = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                unaligned = req_addr[0];
                be_next = 4'b0011 << {req_addr[1], 1'b0};
                wdata_next = {2{req_wdata[15:0]}};
            end
            2'b10: unaligned = (req_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    assign misaligned = req_valid && (illegal || unaligned);
    assign accept     = (state_reg == IDLE) && !done_reg && req_valid && !illegal && !unaligned;
    // Gated by rst_n so the pipeline is released the instant reset asserts.
    assign stall      = rst_n && ((state_reg == BUS) || accept);

    always_comb begin
        lane = mem_rdata >> {addr_lo_reg, 3'b000};
        case (funct3_reg)
            3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext_data = {24'd0, lane[7:0]};
            3'b101:  ext_data = {16'd0, lane[15:0]};
            default: ext_data = lane;
        endcase
    end

    assign cnt_inc     = cnt_reg + 16'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            done_reg    <= 1'b0;
            cnt_reg     <= 16'd0;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'd0;
            addr_lo_reg <= 2'd0;
            load_data   <= 32'd0;
            load_valid  <= 1'b0;
            bus_fault   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
        end else begin
            load_valid <= 1'b0;
            bus_fault  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (done_reg) begin
                        done_reg <= 1'b0;
                    end else if (accept) begin
                        state_reg   <= BUS;
                        cnt_reg     <= 16'd0;
                        we_reg      <= req_we;
                        funct3_reg  <= req_funct3;
                        addr_lo_reg <= req_addr[1:0];
                        mem_req     <= 1'b1;
                        mem_we      <= req_we;
                        mem_addr    <= {req_addr[31:2], 2'b00};
                        mem_be      <= be_next;
                        mem_wdata   <= req_we ? wdata_next : 32'd0;
                    end
                end
                BUS: begin
                    if (mem_ack || timeout_hit) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_be    <= 4'd0;
                        mem_wdata <= 32'd0;
                        // An ack in the final allowed cycle still wins over the timeout.
                        if (mem_ack) begin
                            if (!we_reg) begin
                                load_data  <= ext_data;
                                load_valid <= 1'b1;
                            end
                        end else begin
                            bus_fault <= 1'b1;
                            if (!we_reg) load_data <= 32'd0;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets per-cycle
// expectations, one negedge process compares, plus literal end-of-access checks.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        bus_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .bus_fault(bus_fault), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int err_n = 0;

    logic [31:0] model_ld = 32'd0;
    logic        e_stall = 0, e_req = 0, e_we = 0, e_lv = 0, e_bf = 0, e_mis = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ld = 0;
    logic [3:0]  e_be = 0;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata, seen_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_illegal(logic we, logic [2:0] f3, logic [31:0] addr);
        if (f3[1:0] == 2'b11) return 1'b1;
        if (!we && f3 == 3'b110) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (addr % (32'd1 << f3[1:0])) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] addr);
        int sz = 1 << f3[1:0];
        int m = ((1 << sz) - 1) << int'(addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wdata);
        if (f3[1:0] == 2'b00) return 32'(wdata[7:0]) * 32'h01010101;
        if (f3[1:0] == 2'b01) return 32'(wdata[15:0]) * 32'h00010001;
        return wdata;
    endfunction

    function automatic logic [31:0] m_ext(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] v = rdata >> (8 * (addr % 4));
        if (f3[1:0] == 2'b00) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (f3[1:0] == 2'b01) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic set_idle();
        e_stall = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
        e_lv = 0; e_bf = 0; e_mis = 0; e_ld = model_ld;
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(e_stall));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("load_valid", 32'(load_valid), 32'(e_lv));
        chk("bus_fault", 32'(bus_fault), 32'(e_bf));
        chk("load_data", load_data, e_ld);
        if (req_valid) chk("misaligned", 32'(misaligned), 32'(e_mis));
        if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", 32'(mem_be), 32'(e_be));
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    // waits < 0 means the bus never acks.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                          output logic [31:0] ld_seen, output int stall_cyc, output int req_cyc);
        logic bad = m_illegal(we, f3, addr);
        int nbus = (waits < 0) ? TMO : waits + 1;
        stall_cyc = 0; req_cyc = 0;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_ack = 0;
        set_idle(); e_mis = bad; e_stall = !bad;
        @(negedge clk);
        stall_cyc += int'(stall); req_cyc += int'(mem_req); ld_seen = load_data;
        if (!bad) begin
            for (int i = 0; i < nbus; i++) begin
                @(posedge clk); #1;
                mem_ack = (i == waits);
                mem_rdata = (i == waits) ? rdata : $urandom;
                set_idle();
                e_stall = 1; e_req = 1; e_we = we; e_addr = addr & 32'hFFFFFFFC;
                e_be = m_be(f3, addr); e_wdata = we ? m_wdata(f3, wdata) : 32'd0;
                @(negedge clk);
                stall_cyc += int'(stall); req_cyc += int'(mem_req);
                if (mem_req) begin seen_be = mem_be; seen_wdata = mem_wdata; seen_addr = mem_addr; end
            end
            @(posedge clk); #1;
            mem_ack = 0;
            if (!we) model_ld = (waits < 0) ? 32'd0 : m_ext(f3, addr, rdata);
            set_idle();
            e_lv = !we && waits >= 0; e_bf = waits < 0;
            @(negedge clk);
            stall_cyc += int'(stall); req_cyc += int'(mem_req); ld_seen = load_data;
        end
        @(posedge clk); #1;
        req_valid = 0;
        set_idle();
        @(negedge clk);
    endtask

    logic [2:0]  x_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] x_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] x_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034};

    initial begin
        logic [31:0] ld;
        int sc, rc;
        set_idle();
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_load_data", load_data, 32'd0);
        chk("reset_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);

        access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, ld, sc, rc);
        chk("lw_data", ld, 32'hDEADBEEF);
        chk("lw_stall_len", 32'(sc), 32'd2);
        chk("lw_req_len", 32'(rc), 32'd1);
        chk("lw_be", 32'(seen_be), 32'hF);

        for (int i = 0; i < 5; i++) begin
            access(1'b0, x_f3[i], x_addr[i], 32'd0, 32'h80FF1234, i % 3, ld, sc, rc);
            chk($sformatf("ext_%0d", i), ld, x_exp[i]);
            chk($sformatf("ext_stall_%0d", i), 32'(sc), 32'(2 + i % 3));
        end

        access(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'd0, 3, ld, sc, rc);
        chk("sb_stall_len", 32'(sc), 32'd5);
        chk("sb_load_data_kept", ld, 32'h00000034);
        chk("sb_be", 32'(seen_be), 32'b0010);
        chk("sb_wdata", seen_wdata, 32'hABABABAB);
        chk("sb_addr", seen_addr, 32'h200);

        access(1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'd0, 1, ld, sc, rc);
        chk("sh_be", 32'(seen_be), 32'b1100);
        chk("sh_wdata", seen_wdata, 32'hCDEFCDEF);
        access(1'b1, 3'b010, 32'h20C, 32'hCAFEF00D, 32'd0, 0, ld, sc, rc);
        chk("sw_wdata", seen_wdata, 32'hCAFEF00D);

        access(1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 0, ld, sc, rc);
        chk("lw_mis_stall", 32'(sc), 32'd0);
        chk("lw_mis_req", 32'(rc), 32'd0);
        access(1'b1, 3'b001, 32'h101, 32'hFFFF, 32'd0, 0, ld, sc, rc);
        chk("sh_mis_stall", 32'(sc), 32'd0);
        chk("sh_mis_req", 32'(rc), 32'd0);
        access(1'b1, 3'b100, 32'h100, 32'd1, 32'd0, 0, ld, sc, rc);
        chk("st_illegal_req", 32'(rc), 32'd0);

        access(1'b0, 3'b010, 32'h400, 32'd0, 32'd0, -1, ld, sc, rc);
        chk("tmo_req_len", 32'(rc), 32'd4);
        chk("tmo_stall_len", 32'(sc), 32'd5);
        chk("tmo_load_data", ld, 32'd0);

        access(1'b0, 3'b010, 32'h104, 32'd0, 32'h12345678, 1, ld, sc, rc);
        chk("lw2_data", ld, 32'h12345678);

        // Reset in the second BUS cycle of a load.
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300;
        set_idle(); e_stall = 1;
        @(negedge clk);
        @(posedge clk); #1;
        set_idle(); e_stall = 1; e_req = 1; e_addr = 32'h300; e_be = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 0; req_valid = 0; model_ld = 32'd0; set_idle();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1; mem_ack = 1; mem_rdata = 32'h55555555;
        @(negedge clk);
        chk("late_ack_no_lv", 32'(load_valid), 32'd0);
        @(posedge clk); #1 mem_ack = 0;
        @(negedge clk);
        chk("late_ack_no_lv2", 32'(load_valid), 32'd0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
